// File: rtl/alu_hilo_mux.sv
// alu_hilo_mux: registered writeback selector for the MIPS datapath.
// It owns the HI/LO pair and an iterative unsigned divider (DIVU).
// Define ALU_HILO_MULTU_EN to add an iterative unsigned multiplier (MULTU)
// that shares the counter and RUN state. Without it, MULTU is an unknown funct.
module alu_hilo_mux #(
  parameter int WIDTH   = 32,
  parameter int FUNCT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [FUNCT_W-1:0] Signal,
  input  logic [WIDTH-1:0]   ALUOut,
  input  logic [WIDTH-1:0]   Shifter,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  output logic [WIDTH-1:0]   dataOut,
  output logic               out_valid,
  output logic               busy,
  output logic               stall
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [FUNCT_W-1:0] FN_AND   = FUNCT_W'(6'b100100);
  localparam logic [FUNCT_W-1:0] FN_OR    = FUNCT_W'(6'b100101);
  localparam logic [FUNCT_W-1:0] FN_ADD   = FUNCT_W'(6'b100000);
  localparam logic [FUNCT_W-1:0] FN_SUB   = FUNCT_W'(6'b100010);
  localparam logic [FUNCT_W-1:0] FN_SLT   = FUNCT_W'(6'b101010);
  localparam logic [FUNCT_W-1:0] FN_SRL   = FUNCT_W'(6'b000010);
  localparam logic [FUNCT_W-1:0] FN_DIVU  = FUNCT_W'(6'b011011);
  localparam logic [FUNCT_W-1:0] FN_MFHI  = FUNCT_W'(6'b010000);
  localparam logic [FUNCT_W-1:0] FN_MFLO  = FUNCT_W'(6'b010010);
`ifdef ALU_HILO_MULTU_EN
  localparam logic [FUNCT_W-1:0] FN_MULTU = FUNCT_W'(6'b011001);
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef ALU_HILO_MULTU_EN
  logic             isMult;
  logic [WIDTH:0]   addSum;
  logic [WIDTH-1:0] mulRem;
  logic [WIDTH-1:0] mulQuo;
`endif

  logic             hiloOp;
  logic             accept;
  logic [WIDTH:0]   shiftRem;
  logic [WIDTH:0]   trial;
  logic             divFits;
  logic [WIDTH-1:0] divRem;
  logic [WIDTH-1:0] divQuo;
  logic [WIDTH-1:0] nextRem;
  logic [WIDTH-1:0] nextQuo;

  assign busy   = (state == RUN);
  assign stall  = in_valid & busy & hiloOp;
  assign accept = in_valid & ~stall;

  // Instructions that touch HI/LO or the iterative unit must wait while it runs
  always_comb begin
    hiloOp = 1'b0;
    if (Signal == FN_DIVU || Signal == FN_MFHI || Signal == FN_MFLO)
      hiloOp = 1'b1;
`ifdef ALU_HILO_MULTU_EN
    if (Signal == FN_MULTU)
      hiloOp = 1'b1;
`endif
  end

  // One restoring-divide step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    shiftRem = {rem, quo[WIDTH-1]};
    trial    = shiftRem - {1'b0, opB};
    divFits  = ~trial[WIDTH];
    divRem   = divFits ? trial[WIDTH-1:0] : shiftRem[WIDTH-1:0];
    divQuo   = {quo[WIDTH-2:0], divFits};
  end

`ifdef ALU_HILO_MULTU_EN
  // One shift-add multiply step: {rem, quo} is the product register, quo holds the multiplier
  always_comb begin
    addSum = {1'b0, rem} + (quo[0] ? {1'b0, opB} : {(WIDTH+1){1'b0}});
    mulRem = addSum[WIDTH:1];
    mulQuo = {addSum[0], quo[WIDTH-1:1]};
  end
`endif

  // Pick the step result of whichever iterative operation is running
  always_comb begin
    nextRem = divRem;
    nextQuo = divQuo;
`ifdef ALU_HILO_MULTU_EN
    if (isMult) begin
      nextRem = mulRem;
      nextQuo = mulQuo;
    end
`endif
  end

  // Writeback register, HI/LO pair and the iterative-unit state machine
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      rem       <= '0;
      quo       <= '0;
      opB       <= '0;
      hi        <= '0;
      lo        <= '0;
      dataOut   <= '0;
      out_valid <= 1'b0;
`ifdef ALU_HILO_MULTU_EN
      isMult    <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;

      if (state == RUN) begin
        rem   <= nextRem;
        quo   <= nextQuo;
        count <= count - 1'b1;
        if (count == '0) begin
          state <= IDLE;
          hi    <= nextRem;
          lo    <= nextQuo;
        end
      end

      if (accept) begin
        case (Signal)
          FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT: begin
            dataOut   <= ALUOut;
            out_valid <= 1'b1;
          end
          FN_SRL: begin
            dataOut   <= Shifter;
            out_valid <= 1'b1;
          end
          FN_MFHI: begin
            dataOut   <= hi;
            out_valid <= 1'b1;
          end
          FN_MFLO: begin
            dataOut   <= lo;
            out_valid <= 1'b1;
          end
          FN_DIVU: begin
            state <= RUN;
            count <= CW'(WIDTH - 1);
            rem   <= '0;
            quo   <= src_a;
            opB   <= src_b;
`ifdef ALU_HILO_MULTU_EN
            isMult <= 1'b0;
`endif
          end
`ifdef ALU_HILO_MULTU_EN
          FN_MULTU: begin
            state  <= RUN;
            count  <= CW'(WIDTH - 1);
            rem    <= '0;
            quo    <= src_a;
            opB    <= src_b;
            isMult <= 1'b1;
          end
`endif
          default: begin
            dataOut   <= '0;
            out_valid <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_hilo_mux.sv
// tb_alu_hilo_mux: directed and randomized checks of alu_hilo_mux against a
// behavioural model (plain division/multiplication and a funct lookup).
module tb_alu_hilo_mux;

  localparam int WIDTH   = 32;
  localparam int FUNCT_W = 6;

  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULTU = 6'b011001;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [FUNCT_W-1:0] Signal;
  logic [WIDTH-1:0]  ALUOut;
  logic [WIDTH-1:0]  Shifter;
  logic [WIDTH-1:0]  src_a;
  logic [WIDTH-1:0]  src_b;
  logic [WIDTH-1:0]  dataOut;
  logic              out_valid;
  logic              busy;
  logic              stall;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [31:0] hiM = '0;
  logic [31:0] loM = '0;
  logic [31:0] lastData = '0;

  alu_hilo_mux #(.WIDTH(WIDTH), .FUNCT_W(FUNCT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .Signal(Signal),
    .ALUOut(ALUOut), .Shifter(Shifter), .src_a(src_a), .src_b(src_b),
    .dataOut(dataOut), .out_valid(out_valid), .busy(busy), .stall(stall)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [5:0] sig,
                               input logic [31:0] alu, input logic [31:0] sh,
                               input logic [31:0] a, input logic [31:0] b);
    in_valid = v;
    Signal   = sig;
    ALUOut   = alu;
    Shifter  = sh;
    src_a    = a;
    src_b    = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Reference result of a long operation, straight from the arithmetic definition
  task automatic longModel(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    if (op == F_MULTU) begin
      p   = {32'b0, a} * {32'b0, b};
      hiM = p[63:32];
      loM = p[31:0];
    end else if (b == 32'd0) begin
      loM = 32'hFFFF_FFFF;
      hiM = a;
    end else begin
      loM = a / b;
      hiM = a % b;
    end
  endtask

  // Expected {out_valid, dataOut} for a single accepted (or absent) instruction
  function automatic logic [32:0] expectOp(input logic v, input logic [5:0] sig,
                                           input logic [31:0] alu, input logic [31:0] sh);
    if (!v) return {1'b0, lastData};
    if (sig == F_AND || sig == F_OR || sig == F_ADD || sig == F_SUB || sig == F_SLT)
      return {1'b1, alu};
    if (sig == F_SRL)  return {1'b1, sh};
    if (sig == F_MFHI) return {1'b1, hiM};
    if (sig == F_MFLO) return {1'b1, loM};
    return {1'b1, 32'h0};
  endfunction

  task automatic readHiLo(input string tag);
    applyStimulus(1'b1, F_MFLO, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    checkOutput({tag, " LO"}, dataOut, loM);
    checkOutput({tag, " LO valid"}, {31'b0, out_valid}, 32'd1);
    applyStimulus(1'b1, F_MFHI, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    checkOutput({tag, " HI"}, dataOut, hiM);
    lastData = hiM;
  endtask

  // Count busy cycles until the unit goes idle; optionally issue an ADD mid-run
  task automatic waitBusy(input string tag, input bit midAdd);
    int n;
    logic [31:0] r;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (midAdd && n == 5) begin
        r = $urandom;
        applyStimulus(1'b1, F_ADD, r, 32'h0, 32'h0, 32'h0);
        checkOutput({tag, " mid add stall"}, {31'b0, stall}, 32'd0);
        tick();
        checkOutput({tag, " mid add data"}, dataOut, r);
      end else begin
        applyStimulus(1'b0, F_ADD, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
      end
    end
    checkOutput({tag, " busy cycles"}, n, 32'd32);
  endtask

  task automatic runLong(input string tag, input logic [5:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    applyStimulus(1'b1, op, 32'h0, 32'h0, a, b);
    checkOutput({tag, " start stall"}, {31'b0, stall}, 32'd0);
    tick();
    checkOutput({tag, " no writeback"}, {31'b0, out_valid}, 32'd0);
    longModel(op, a, b);
    waitBusy(tag, 1'b1);
    readHiLo(tag);
  endtask

  initial begin
    int n;
    logic [32:0] exp;
    logic [5:0]  sig;
    logic [31:0] r1, r2, a2, b2;
    logic        v;
    logic [5:0]  opTable [10];
    opTable = '{F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SRL, F_MFHI, F_MFLO, 6'b111111, 6'b000000};

    // Reset and idle
    rst = 1'b1;
    applyStimulus(1'b0, 6'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset dataOut", dataOut, 32'h0);
    checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    readHiLo("reset");

    // ALU and shifter passthrough, then an idle cycle that holds dataOut
    applyStimulus(1'b1, F_ADD, 32'h0000_1234, 32'h0, 32'h0, 32'h0);
    tick();
    checkOutput("add data", dataOut, 32'h0000_1234);
    checkOutput("add valid", {31'b0, out_valid}, 32'd1);
    applyStimulus(1'b1, F_SRL, 32'h0, 32'h8000_0000, 32'h0, 32'h0);
    tick();
    checkOutput("srl data", dataOut, 32'h8000_0000);
    applyStimulus(1'b0, F_ADD, 32'h5555_5555, 32'h0, 32'h0, 32'h0);
    tick();
    checkOutput("idle valid", {31'b0, out_valid}, 32'd0);
    checkOutput("idle hold", dataOut, 32'h8000_0000);

    // Directed and random divides
    runLong("divu 100/7", F_DIVU, 32'd100, 32'd7);
    runLong("divu by zero", F_DIVU, 32'hDEAD_BEEF, 32'h0);
    for (int i = 0; i < 3; i++) begin
      r1 = $urandom;
      r2 = (i == 0) ? $urandom_range(1, 255) : $urandom;
      runLong("divu random", F_DIVU, r1, r2);
    end

    // MFHI held from the cycle after DIVU stalls for the whole run
    r1 = $urandom;
    r2 = $urandom_range(1, 1000);
    applyStimulus(1'b1, F_DIVU, 32'h0, 32'h0, r1, r2);
    tick();
    longModel(F_DIVU, r1, r2);
    applyStimulus(1'b1, F_MFHI, 32'h0, 32'h0, 32'h0, 32'h0);
    n = 0;
    while (stall === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    checkOutput("mfhi stall cycles", n, 32'd32);
    tick();
    checkOutput("mfhi after stall", dataOut, hiM);
    checkOutput("mfhi after stall valid", {31'b0, out_valid}, 32'd1);
    lastData = hiM;

    // Back-to-back DIVU: second one starts the cycle busy drops
    r1 = $urandom;
    r2 = $urandom;
    a2 = $urandom;
    b2 = $urandom_range(1, 65535);
    applyStimulus(1'b1, F_DIVU, 32'h0, 32'h0, r1, r2);
    tick();
    applyStimulus(1'b1, F_DIVU, 32'h0, 32'h0, a2, b2);
    n = 0;
    while (stall === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    checkOutput("b2b stall cycles", n, 32'd32);
    tick();
    checkOutput("b2b restart busy", {31'b0, busy}, 32'd1);
    longModel(F_DIVU, a2, b2);
    waitBusy("b2b second", 1'b0);
    readHiLo("b2b second");

    // Random single-cycle instruction mix
    for (int i = 0; i < 24; i++) begin
      v   = ($urandom_range(0, 4) != 0);
      sig = opTable[$urandom_range(0, 9)];
      r1  = $urandom;
      r2  = $urandom;
      exp = expectOp(v, sig, r1, r2);
      applyStimulus(v, sig, r1, r2, $urandom, $urandom);
      tick();
      checkOutput("random op data", dataOut, exp[31:0]);
      checkOutput("random op valid", {31'b0, out_valid}, {31'b0, exp[32]});
      lastData = exp[31:0];
    end

`ifdef ALU_HILO_MULTU_EN
    runLong("multu ffffffff*2", F_MULTU, 32'hFFFF_FFFF, 32'd2);
    runLong("multu random", F_MULTU, $urandom, $urandom);
`else
    applyStimulus(1'b1, F_ADD, 32'hCAFE_F00D, 32'h0, 32'h0, 32'h0);
    tick();
    applyStimulus(1'b1, F_MULTU, 32'h1111_1111, 32'h0, 32'h3, 32'h4);
    tick();
    checkOutput("multu unknown data", dataOut, 32'h0);
    checkOutput("multu unknown valid", {31'b0, out_valid}, 32'd1);
    checkOutput("multu unknown busy", {31'b0, busy}, 32'd0);
    lastData = 32'h0;
`endif

    // Reset ten cycles into a divide aborts it and clears HI/LO
    applyStimulus(1'b1, F_DIVU, 32'h0, 32'h0, 32'd1000, 32'd3);
    tick();
    applyStimulus(1'b0, F_ADD, 32'h0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    checkOutput("abort busy", {31'b0, busy}, 32'd0);
    checkOutput("abort out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("abort dataOut", dataOut, 32'h0);
    rst = 1'b0;
    hiM = '0;
    loM = '0;
    for (int i = 0; i < 35; i++) tick();
    readHiLo("abort");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
